// File: rtl/color_pkg.sv
// Shared constants, pixel type and length helpers for the color serializer.
package color_pkg;

  localparam int unsigned DN_DEF = 4;
  localparam int unsigned CN_DEF = 3;
  localparam int unsigned DW_DEF = 8;

  // r/g/b pixel for the CN=3, DW=8 case; r occupies the top channel.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } t_color;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } t_state;

  // Width of a pixel index within a vector of dn pixels (at least one bit).
  function automatic int unsigned idx_width(input int unsigned dn);
    return (dn > 1) ? $clog2(dn) : 1;
  endfunction

  // Width able to hold a length of 0..dn.
  function automatic int unsigned len_width(input int unsigned dn);
    return $clog2(dn + 1);
  endfunction

  // Saturate a requested length: 0 or anything above dn means a full vector.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned dn);
    return (len == 0 || len > dn) ? dn : len;
  endfunction

endpackage

// File: rtl/color_serializer_if.sv
// Vector-in / pixel-out stream bundle between a wide source and the serializer.
interface color_serializer_if
  import color_pkg::*;
#(
  parameter int unsigned DN = DN_DEF,
  parameter int unsigned CN = CN_DEF,
  parameter int unsigned DW = DW_DEF
);

  localparam int unsigned IW = idx_width(DN);
  localparam int unsigned LW = len_width(DN);

  logic                           s_valid;
  logic                           s_ready;
  logic [DN-1:0][CN-1:0][DW-1:0]  s_data;
  logic [LW-1:0]                  s_len;
  logic                           s_rev;
  logic                           m_valid;
  logic                           m_ready;
  logic [CN-1:0][DW-1:0]          m_data;
  logic [IW-1:0]                  m_index;
  logic                           m_last;

  modport master (
    output s_valid, s_data, s_len, s_rev, m_ready,
    input  s_ready, m_valid, m_data, m_index, m_last
  );

  modport slave (
    input  s_valid, s_data, s_len, s_rev, m_ready,
    output s_ready, m_valid, m_data, m_index, m_last
  );

endinterface

// File: rtl/color_serializer.sv
// Serializes a held vector of DN pixels onto a one-pixel-per-cycle stream.
module color_serializer
  import color_pkg::*;
#(
  parameter int unsigned DN = DN_DEF,
  parameter int unsigned CN = CN_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input logic              clk,
  input logic              rst,
  color_serializer_if.slave bus
);

  localparam int unsigned IW = idx_width(DN);
  localparam int unsigned LW = len_width(DN);

  t_state                         state_q, state_d;
  logic [IW-1:0]                  cnt_q, cnt_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [LW-1:0]                  len_q, len_d;
  logic                           rev_q, rev_d;
  logic [DN-1:0][CN-1:0][DW-1:0]  buf_q, buf_d;
  logic                           valid_q, valid_d;
  logic [CN-1:0][DW-1:0]          data_q, data_d;
  logic                           last_q, last_d;
  logic [LW-1:0]                  len_in;
  logic                           out_hs;
  logic                           in_hs;

  // Accept a new vector when idle or while the last pixel is being taken.
  assign out_hs      = valid_q && bus.m_ready;
  assign bus.s_ready = (state_q == ST_IDLE) || (out_hs && last_q);
  assign in_hs       = bus.s_valid && bus.s_ready;
  assign len_in      = LW'(eff_len(32'(bus.s_len), DN));

  assign bus.m_valid = valid_q;
  assign bus.m_data  = data_q;
  assign bus.m_index = idx_q;
  assign bus.m_last  = last_q;

  // Next-state: load a vector, step through its pixels, or drop back to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    rev_d   = rev_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;

    if (in_hs) begin
      state_d = ST_SEND;
      buf_d   = bus.s_data;
      len_d   = len_in;
      rev_d   = bus.s_rev;
      cnt_d   = '0;
      idx_d   = bus.s_rev ? IW'(len_in - LW'(1)) : '0;
      data_d  = bus.s_data[idx_d];
      last_d  = (len_in == LW'(1));
      valid_d = 1'b1;
    end else if (out_hs) begin
      if (last_q) begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end else begin
        cnt_d  = cnt_q + IW'(1);
        idx_d  = rev_q ? (idx_q - IW'(1)) : (idx_q + IW'(1));
        data_d = buf_q[idx_d];
        last_d = (LW'(cnt_d) == (len_q - LW'(1)));
      end
    end
  end

  // State and output registers; reset discards any vector in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      rev_q   <= 1'b0;
      buf_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      rev_q   <= rev_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: doc/color_serializer.md
# color_serializer

Parametrised successor to the fixed round-robin color mux. Accepts a packed vector of DN pixels of CN channels each through a valid/ready handshake and emits the pixels one per cycle on a valid/ready output stream, with back-pressure, variable vector length, element order selection and last/index markers. It sits between a wide pixel source and a single-pixel-per-clock consumer, for example a display or channel-split path.

## Interface
- DN, 4: pixels per input vector, ≥1
- CN, 3: channels per pixel, ≥1
- DW, 8: bits per channel, ≥1
- IW, derived: $clog2(DN), minimum 1; index width
- LW, derived: $clog2(DN+1); length width
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- s_valid  input  1  input vector valid
- s_ready  output  1  input vector accepted when s_valid && s_ready
- s_data  input  DN*CN*DW  packed [DN-1:0][CN-1:0][DW-1:0]; pixel j is s_data[j]
- s_len  input  LW  pixels to emit, 1..DN; 0 or >DN means DN
- s_rev  input  1  0: emit pixel 0 first; 1: emit pixel len-1 first
- m_valid  output  1  output pixel valid
- m_ready  input  1  consumer ready
- m_data  output  CN*DW  packed [CN-1:0][DW-1:0] pixel
- m_index  output  IW  source index of the current pixel within its vector
- m_last  output  1  current pixel is the final pixel of its vector

## Operation
- Holding register captures s_data, effective length L and s_rev on an input handshake.
- State machine:
  - IDLE: m_valid=0, s_ready=1. On handshake, go to SEND with cnt=0.
  - SEND: m_valid=1. Output index is cnt (forward) or L-1-cnt (reverse). m_data is the held pixel at that index. m_last=(cnt==L-1).
- Output handshake (m_valid && m_ready):
  - If not last, cnt+1.
  - If last and s_valid, reload from the new vector, cnt=0, stay in SEND. This gives back-to-back vectors with no bubble.
  - If last and no s_valid, go to IDLE.
- s_ready = IDLE || (m_valid && m_ready && m_last). This is combinational from m_ready; that is the only comb path.
- If m_ready is low, m_data, m_index and m_last hold stable. m_valid never deasserts without a handshake.
- s_data and s_len are sampled only at the handshake. Changes at other times have no effect.

## Timing
- Reset values: m_valid=0, m_data=0, m_index=0, m_last=0, cnt=0, state IDLE. s_ready=1 after reset.
- Latency: handshake at edge N gives the first pixel valid after edge N, i.e. one cycle.
- Throughput: one pixel per cycle with m_ready held high, including across vector boundaries. A vector of L pixels occupies exactly L cycles.
- L=1: every pixel is last, and s_ready is high in every SEND cycle while m_ready=1.
- Reset mid-vector: outputs clear immediately and remaining pixels are discarded.
- Synthesis requirement: m_data comes from a register, not a comb mux behind the handshake.

## Structure
- Shared package color_pkg:
  - default constants for DN, CN, DW
  - t_color typedef for the CN=3, DW=8 r/g/b case
  - a function to saturate length to an effective L
- Single flat module. No sub-module is warranted; the counter and mux are small.

## Test plan
- Reset then idle: m_valid=0, s_ready=1, m_data=0.
- DN=4, CN=3, DW=8, pixel j={3{8'h10+j}}, s_len=0, s_rev=0, m_ready=1:
  - m_data sequence 101010, 111111, 121212, 131313
  - m_index 0..3, m_last only on the 4th pixel, done in 4 cycles
- Same vector, s_len=3, s_rev=1: indices 2,1,0 with m_last on index 0.
- Two vectors offered back-to-back with m_ready=1: 8 consecutive valid cycles with no gap. The second s_ready pulse coincides with the first m_last.
- m_ready toggled 1,0,0,1,...: outputs are stable during stalls, no pixel is lost or repeated, and the total of 4 handshakes per vector is preserved.
- Assert rst while at index 2: m_valid=0 asynchronously. After release, a new vector starts at index 0.
